// File: rtl/matmul_job_scheduler.sv
// matmul_job_scheduler
//   Queues matrix-multiply job descriptors (K depth + job ID) and runs them
//   on the compute engine one at a time. Each job has a watchdog. Each finished
//   job produces a completion record and sets a sticky interrupt.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   s_job_*               job submit stream (valid/ready), K and ID
//   enable                allows new jobs to be popped from the queue
//   cfg_timeout           watchdog limit in cycles, 0 disables it
//   eng_start/eng_cfg_k   engine start level and K of the current job
//   eng_done_pulse        engine completion event (only honoured in RUN)
//   eng_abort             one-cycle pulse when the watchdog expires
//   m_cmp_*               completion stream (valid/ready), ID and status
//   irq_en, irq_clear     interrupt mask and clear; irq = pending & irq_en
//   busy                  FSM is not in IDLE
//   queue_level           number of queued jobs
//   dbg_state             current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and payload stable until that transfer. The ready
// signals here never depend on the matching valid.

module matmul_job_scheduler #(
  parameter int K_W   = 16,
  parameter int K_MAX = 64,
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int TMO_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_job_valid,
  output logic                     s_job_ready,
  input  logic [K_W-1:0]           s_job_k,
  input  logic [ID_W-1:0]          s_job_id,
  input  logic                     enable,
  input  logic [TMO_W-1:0]         cfg_timeout,
  output logic                     eng_start,
  output logic [K_W-1:0]           eng_cfg_k,
  input  logic                     eng_done_pulse,
  output logic                     eng_abort,
  output logic                     m_cmp_valid,
  input  logic                     m_cmp_ready,
  output logic [ID_W-1:0]          m_cmp_id,
  output logic [1:0]               m_cmp_status,
  input  logic                     irq_en,
  input  logic                     irq_clear,
  output logic                     irq,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_level,
  output logic [2:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [K_W-1:0] K_MAX_V  = K_W'(K_MAX);
  localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_BAD_K = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RUN     = 3'd2,
    RELEASE = 3'd3,
    REPORT  = 3'd4
  } state_t;

  state_t state, state_next;

  // ---------------------------------------------------------------- FIFO
  logic [K_W+ID_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level;
  logic                empty;
  logic                push, pop;
  logic [K_W+ID_W-1:0] head;
  logic [K_W-1:0]      head_k;
  logic [ID_W-1:0]     head_id;
  logic                head_bad;

  assign empty       = (level == '0);
  assign s_job_ready = (level != FULL_LVL);
  assign queue_level = level;
  assign push        = s_job_valid && s_job_ready;
  assign pop         = (state == IDLE) && enable && !empty;

  assign head     = mem[rd_ptr];
  assign head_k   = head[K_W+ID_W-1:ID_W];
  assign head_id  = head[ID_W-1:0];
  assign head_bad = (head_k == '0) || (head_k > K_MAX_V);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_job_k, s_job_id};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------- job datapath
  logic [ID_W-1:0]  cur_id;
  logic [1:0]       status;
  logic [K_W-1:0]   cfg_k_q;
  logic [TMO_W-1:0] tmo_lim;
  logic [TMO_W-1:0] tmo_cnt;
  logic             irq_pending;
  logic             timeout_hit;
  logic             cmp_hs;

  assign timeout_hit = (state == RUN) && (tmo_lim != '0) &&
                       (tmo_cnt == tmo_lim - TMO_W'(1));
  assign cmp_hs      = (state == REPORT) && m_cmp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_id      <= '0;
      status      <= ST_OK;
      cfg_k_q     <= '0;
      tmo_lim     <= '0;
      tmo_cnt     <= '0;
      irq_pending <= 1'b0;
    end else begin
      if (pop) begin
        cur_id  <= head_id;
        tmo_lim <= cfg_timeout;
        status  <= head_bad ? ST_BAD_K : ST_OK;
        // Rejected jobs never reach the engine, so its K is left untouched.
        if (!head_bad) cfg_k_q <= head_k;
      end

      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if ((state == RUN) && (tmo_cnt != '1)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      // Done takes priority over a watchdog expiry in the same cycle.
      if (state == RUN) begin
        if (eng_done_pulse)   status <= ST_OK;
        else if (timeout_hit) status <= ST_TMO;
      end

      // A new completion outranks a simultaneous clear.
      if (cmp_hs)         irq_pending <= 1'b1;
      else if (irq_clear) irq_pending <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = head_bad ? REPORT : ISSUE;
      ISSUE:   state_next = RUN;
      RUN:     if (eng_done_pulse || timeout_hit) state_next = RELEASE;
      RELEASE: state_next = REPORT;
      REPORT:  if (m_cmp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    eng_start    = (state == RUN);
    busy         = (state != IDLE);
    m_cmp_valid  = (state == REPORT);
    eng_abort    = timeout_hit && !eng_done_pulse;
    eng_cfg_k    = cfg_k_q;
    m_cmp_id     = cur_id;
    m_cmp_status = status;
    irq          = irq_pending & irq_en;
    dbg_state    = state;
  end

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Testbench for matmul_job_scheduler: table of single-job vectors plus
// hand-written sequences for ordering, backpressure, queue-full and reset.

module tb_matmul_job_scheduler;

  localparam int K_W   = 16;
  localparam int ID_W  = 4;
  localparam int TMO_W = 20;
  localparam int DEPTH = 4;

  // ---------------------------------------------------------------- clock/reset and DUT
  logic              clk;
  logic              rst_n;
  logic              s_job_valid;
  logic              s_job_ready;
  logic [K_W-1:0]    s_job_k;
  logic [ID_W-1:0]   s_job_id;
  logic              enable;
  logic [TMO_W-1:0]  cfg_timeout;
  logic              eng_start;
  logic [K_W-1:0]    eng_cfg_k;
  logic              eng_done_pulse;
  logic              eng_abort;
  logic              m_cmp_valid;
  logic              m_cmp_ready;
  logic [ID_W-1:0]   m_cmp_id;
  logic [1:0]        m_cmp_status;
  logic              irq_en;
  logic              irq_clear;
  logic              irq;
  logic              busy;
  logic [2:0]        queue_level;
  logic [2:0]        dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  matmul_job_scheduler #(
    .K_W(K_W), .K_MAX(64), .DEPTH(DEPTH), .ID_W(ID_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_job_valid(s_job_valid), .s_job_ready(s_job_ready),
    .s_job_k(s_job_k), .s_job_id(s_job_id),
    .enable(enable), .cfg_timeout(cfg_timeout),
    .eng_start(eng_start), .eng_cfg_k(eng_cfg_k),
    .eng_done_pulse(eng_done_pulse), .eng_abort(eng_abort),
    .m_cmp_valid(m_cmp_valid), .m_cmp_ready(m_cmp_ready),
    .m_cmp_id(m_cmp_id), .m_cmp_status(m_cmp_status),
    .irq_en(irq_en), .irq_clear(irq_clear), .irq(irq),
    .busy(busy), .queue_level(queue_level), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_cmp = 0;
  int n_err = 0;
  logic [ID_W+1:0] exp_q[$];
  int cmp_cnt   = 0;
  int done_after = 0;
  int run_cnt   = 0;
  int last_run  = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  int abort_at  = 0;
  logic prev_start = 1'b0;
  logic [K_W-1:0] prev_cfg = '0;
  logic [K_W-1:0] exp_k = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_status(input logic [K_W-1:0] k, input int delay,
                                              input logic [TMO_W-1:0] tmo);
    if (k == 0 || k > 64) return 2'b01;
    if (delay != 0 && (tmo == 0 || delay <= int'(tmo))) return 2'b00;
    return 2'b10;
  endfunction

  // ---------------------------------------------------------------- engine model + run monitor
  initial begin
    eng_done_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        if (!prev_start) begin
          start_cnt++;
          check("cfg_k_before_start", prev_cfg, exp_k);
        end
        check("cfg_k_stable", eng_cfg_k, exp_k);
        run_cnt++;
        eng_done_pulse = (done_after != 0) && (run_cnt == done_after);
      end else begin
        if (prev_start) last_run = run_cnt;
        run_cnt = 0;
        eng_done_pulse = 1'b0;
      end
      prev_start = eng_start;
      prev_cfg   = eng_cfg_k;
      #1;
      if (eng_abort) begin
        abort_cnt++;
        abort_at = run_cnt;
      end
    end
  end

  // ---------------------------------------------------------------- completion scoreboard
  initial begin
    logic [ID_W+1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (m_cmp_valid && m_cmp_ready) begin
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_cmp", {m_cmp_id, m_cmp_status}, '1);
        end else begin
          e = exp_q.pop_front();
          check("cmp_id_status", {m_cmp_id, m_cmp_status}, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic push(input logic [K_W-1:0] k, input logic [ID_W-1:0] id,
                      input bit expect_cmp, input logic [1:0] st);
    int waited = 0;
    s_job_valid = 1'b1;
    s_job_k     = k;
    s_job_id    = id;
    while (!s_job_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("push_accepted", s_job_ready, 1);
    if (s_job_ready && expect_cmp) exp_q.push_back({id, st});
    @(negedge clk);
    s_job_valid = 1'b0;
  endtask

  task automatic wait_cmp(input int target, input int max_cycles);
    int n = 0;
    while (cmp_cnt < target && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("wait_cmp", cmp_cnt >= target, 1);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [K_W-1:0]   k;
    logic [ID_W-1:0]  id;
    int               delay;
    logic [TMO_W-1:0] tmo;
    logic [1:0]       exp_status;
    int               exp_run;
    int               exp_abort;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #20000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0, a0, c0, n;

    vecs[0] = '{16'd4,     4'd3,  10, 20'd0, 2'b00, 10, 0};
    vecs[1] = '{16'd0,     4'd1,  5,  20'd0, 2'b01, 0,  0};
    vecs[2] = '{16'd65,    4'd2,  5,  20'd0, 2'b01, 0,  0};
    vecs[3] = '{16'd64,    4'd5,  3,  20'd0, 2'b00, 3,  0};
    vecs[4] = '{16'd1,     4'd7,  1,  20'd0, 2'b00, 1,  0};
    vecs[5] = '{16'd8,     4'd9,  0,  20'd8, 2'b10, 8,  1};
    vecs[6] = '{16'd8,     4'd10, 8,  20'd8, 2'b00, 8,  0};
    vecs[7] = '{16'd16,    4'd11, 5,  20'd8, 2'b00, 5,  0};
    vecs[8] = '{16'd2,     4'd12, 0,  20'd1, 2'b10, 1,  1};
    vecs[9] = '{16'd65535, 4'd13, 0,  20'd4, 2'b01, 0,  0};

    rst_n = 1'b0; s_job_valid = 1'b0; s_job_k = '0; s_job_id = '0;
    enable = 1'b1; cfg_timeout = '0; m_cmp_ready = 1'b1;
    irq_en = 1'b1; irq_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_eng_start", eng_start, 0);
    check("rst_busy", busy, 0);
    check("rst_cmp_valid", m_cmp_valid, 0);
    check("rst_queue_level", queue_level, 0);
    check("rst_job_ready", s_job_ready, 1);
    check("rst_irq", irq, 0);
    check("rst_cfg_k", eng_cfg_k, 0);
    check("rst_cmp_id", m_cmp_id, 0);
    check("rst_cmp_status", m_cmp_status, 0);
    check("rst_state_idle", dbg_state, 0);

    // Single-job table
    for (int i = 0; i < 10; i++) begin
      cfg_timeout = vecs[i].tmo;
      done_after  = vecs[i].delay;
      exp_k       = vecs[i].k;
      s0 = start_cnt; a0 = abort_cnt; c0 = cmp_cnt;
      push(vecs[i].k, vecs[i].id, 1'b1, vecs[i].exp_status);
      wait_cmp(c0 + 1, 300);
      check("started", start_cnt - s0, (vecs[i].exp_run != 0) ? 1 : 0);
      if (vecs[i].exp_run != 0) check("run_len", last_run, vecs[i].exp_run);
      check("abort_cnt", abort_cnt - a0, vecs[i].exp_abort);
      if (vecs[i].exp_abort != 0) check("abort_cycle", abort_at, vecs[i].exp_run);
      check("irq_set", irq, 1);
      irq_clear = 1'b1;
      @(negedge clk);
      irq_clear = 1'b0;
      check("irq_cleared", irq, 0);
    end

    // Back-to-back bad and good jobs complete in order
    cfg_timeout = '0; done_after = 3; exp_k = 16'd64;
    s0 = start_cnt; c0 = cmp_cnt;
    push(16'd0,  4'd1, 1'b1, model_status(16'd0,  done_after, cfg_timeout));
    push(16'd65, 4'd2, 1'b1, model_status(16'd65, done_after, cfg_timeout));
    push(16'd64, 4'd5, 1'b1, model_status(16'd64, done_after, cfg_timeout));
    wait_cmp(c0 + 3, 300);
    check("order_starts", start_cnt - s0, 1);
    check("order_run_len", last_run, 3);

    // Queue fills while disabled; the fifth job waits for space
    enable = 1'b0; done_after = 2; exp_k = 16'd2;
    s0 = start_cnt; c0 = cmp_cnt;
    for (int i = 0; i < 4; i++) push(16'd2, ID_W'(i), 1'b1, 2'b00);
    check("full_level", queue_level, 4);
    check("full_ready", s_job_ready, 0);
    check("full_busy", busy, 0);
    s_job_valid = 1'b1; s_job_k = 16'd2; s_job_id = 4'd4;
    repeat (3) @(negedge clk);
    check("full_hold_level", queue_level, 4);
    check("disabled_no_start", start_cnt - s0, 0);
    enable = 1'b1;
    push(16'd2, 4'd4, 1'b1, 2'b00);
    wait_cmp(c0 + 5, 500);
    check("drain_level", queue_level, 0);
    check("drain_starts", start_cnt - s0, 5);

    // Completion backpressure and irq set/clear collision
    done_after = 2; exp_k = 16'd3; m_cmp_ready = 1'b0;
    c0 = cmp_cnt;
    push(16'd3, 4'd6, 1'b1, 2'b00);
    push(16'd3, 4'd7, 1'b1, 2'b00);
    n = 0;
    while (!m_cmp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", m_cmp_valid, 1);
      check("bp_id", m_cmp_id, 6);
      check("bp_status", m_cmp_status, 0);
      check("bp_no_start", eng_start, 0);
      check("bp_level", queue_level, 1);
    end
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    check("bp_irq_cleared", irq, 0);
    m_cmp_ready = 1'b1;
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    check("irq_set_wins", irq, 1);
    check("bp_one_cmp", cmp_cnt - c0, 1);
    wait_cmp(c0 + 2, 100);

    // Reset in the middle of RUN
    done_after = 0; cfg_timeout = '0; exp_k = 16'd5;
    push(16'd5, 4'd8, 1'b0, 2'b00);
    push(16'd5, 4'd9, 1'b0, 2'b00);
    n = 0;
    while (!eng_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("pre_rst_irq", irq, 1);
    rst_n = 1'b0;
    #1;
    check("rst_waits_edge_start", eng_start, 1);
    check("rst_waits_edge_level", queue_level, 1);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_eng_start", eng_start, 0);
    check("midrst_level", queue_level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmp_valid", m_cmp_valid, 0);
    check("midrst_irq", irq, 0);
    check("midrst_cfg_k", eng_cfg_k, 0);
    c0 = cmp_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_cmp", cmp_cnt - c0, 0);

    // Recovery after reset
    done_after = 4; exp_k = 16'd7;
    c0 = cmp_cnt;
    push(16'd7, 4'd14, 1'b1, 2'b00);
    wait_cmp(c0 + 1, 100);
    check("recover_run_len", last_run, 4);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
